// File: rtl/freq_absorb_pkg.sv
// Shared defaults, FSM encoding and round-robin pick helper
// for the AXI-Stream round-robin arbiter.
package freq_absorb_pkg;

    localparam int DATA_W_DEF  = 256;
    localparam int TUSER_W_DEF = 128;
    localparam int N_PORTS_DEF = 4;
    localparam int CNT_W       = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Returns {found, index}; scans ptr, ptr+1, ... modulo n (n <= 8).
    function automatic logic [3:0] rr_pick(
        input logic [7:0] valid,
        input logic [2:0] ptr,
        input int         n
    );
        logic [3:0] idx;
        logic       found;
        logic [2:0] win;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(n)) idx = idx - 4'(n);
            if (k < n && !found && valid[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
        return {found, win};
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the N requester streams and the merged output stream.
// master: arbiter side; slave: requesters plus downstream sink.
interface axis_rr_arbiter_if #(
    parameter int N_PORTS = freq_absorb_pkg::N_PORTS_DEF,
    parameter int DATA_W  = freq_absorb_pkg::DATA_W_DEF,
    parameter int TUSER_W = freq_absorb_pkg::TUSER_W_DEF
);
    logic [N_PORTS*DATA_W-1:0]     s_axis_tdata;
    logic [N_PORTS*DATA_W/8-1:0]   s_axis_tkeep;
    logic [N_PORTS*TUSER_W-1:0]    s_axis_tuser;
    logic [N_PORTS-1:0]            s_axis_tvalid;
    logic [N_PORTS-1:0]            s_axis_tlast;
    logic [N_PORTS-1:0]            s_axis_tready;

    logic [DATA_W-1:0]             m_axis_tdata;
    logic [DATA_W/8-1:0]           m_axis_tkeep;
    logic [TUSER_W-1:0]            m_axis_tuser;
    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic                          m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser,
        input  s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        output m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser,
        output s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        input  m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_reg_slice.sv
// One-deep forward-registered AXI-Stream slice.
// Accepts a beat when empty or when the held beat is leaving.
module axis_reg_slice #(
    parameter int DW = 256,
    parameter int KW = 32,
    parameter int UW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [KW-1:0] in_keep,
    input  logic [UW-1:0] in_user,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [KW-1:0] out_keep,
    output logic [UW-1:0] out_user,
    output logic          out_last
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_user  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_user  <= in_user;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin merge of N AXI-Stream requesters
// into one registered output stream, with per-port packet counters.
module axis_rr_arbiter
    import freq_absorb_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DATA_W_DEF,
    parameter int C_S_AXIS_TUSER_WIDTH = TUSER_W_DEF,
    parameter int N_PORTS              = N_PORTS_DEF
) (
    input  logic                     axis_aclk,
    input  logic                     axis_reset,
    axis_rr_arbiter_if.master        bus,
    output logic [N_PORTS-1:0]       o_grant,
    output logic [N_PORTS*CNT_W-1:0] o_pkt_cnt
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    arb_state_e         state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [3:0]         pick;
    logic               in_ready, acc, acc_last;
    logic [DW-1:0]      sel_data;
    logic [KW-1:0]      sel_keep;
    logic [UW-1:0]      sel_user;
    logic               sel_last;

    assign pick    = rr_pick(8'(bus.s_axis_tvalid), ptr_q, N_PORTS);
    assign o_grant = grant_q;

    // Grant is one-hot, so a priority mux reduces to a plain select.
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_user = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                sel_data = bus.s_axis_tdata[i*DW +: DW];
                sel_keep = bus.s_axis_tkeep[i*KW +: KW];
                sel_user = bus.s_axis_tuser[i*UW +: UW];
                sel_last = bus.s_axis_tlast[i];
            end
        end
    end

    assign bus.s_axis_tready =
        (state_q == ST_BUSY && in_ready) ? grant_q : '0;
    assign acc      = |(bus.s_axis_tvalid & bus.s_axis_tready);
    assign acc_last = acc && sel_last;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick[3]) begin
                    state_d = ST_BUSY;
                    grant_d = N_PORTS'(1) << pick[2:0];
                    ptr_d   = (pick[2:0] == 3'(N_PORTS - 1)) ?
                              3'd0 : pick[2:0] + 3'd1;
                end
            end
            ST_BUSY: begin
                if (acc_last) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset)                cnt_q <= '0;
            else if (acc_last && grant_q[i]) cnt_q <= cnt_q + 1'b1;
        end
        assign o_pkt_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

    axis_reg_slice #(.DW(DW), .KW(KW), .UW(UW)) u_slice (
        .clk       (axis_aclk),
        .rst       (axis_reset),
        .in_valid  (acc),
        .in_ready  (in_ready),
        .in_data   (sel_data),
        .in_keep   (sel_keep),
        .in_user   (sel_user),
        .in_last   (sel_last),
        .out_valid (bus.m_axis_tvalid),
        .out_ready (bus.m_axis_tready),
        .out_data  (bus.m_axis_tdata),
        .out_keep  (bus.m_axis_tkeep),
        .out_user  (bus.m_axis_tuser),
        .out_last  (bus.m_axis_tlast)
    );
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, arbitration order,
// backpressure, stalled requester, mid-packet reset, counter wrap.
module tb_axis_rr_arbiter;
    import freq_absorb_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int UW = TUSER_W_DEF;
    localparam int KW = DW / 8;
    localparam int N  = N_PORTS_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.N_PORTS(N), .DATA_W(DW), .TUSER_W(UW)) bus ();
    logic [N-1:0]    grant;
    logic [N*32-1:0] cnt;

    axis_rr_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .N_PORTS              (N)
    ) dut (
        .axis_aclk  (clk),
        .axis_reset (rst),
        .bus        (bus),
        .o_grant    (grant),
        .o_pkt_cnt  (cnt)
    );

    int total = 0;
    int bad   = 0;
    int rem  [N];
    int len  [N];
    int beat [N];
    bit pause[N];
    bit toggle;
    bit chk_hold;
    logic [DW-1:0]  outq[$];
    logic           lastq[$];
    logic           vq[$];
    logic [N-1:0]   grantq[$];

    function automatic logic [DW-1:0] mk(int p, int b);
        return DW'(p * 16 + b);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            rem[p] = 0; len[p] = 1; beat[p] = 0; pause[p] = 1'b0;
        end
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        toggle   = 1'b0;
        chk_hold = 1'b0;
        outq.delete(); lastq.delete(); vq.delete(); grantq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cycle();
        logic          stall;
        logic [DW-1:0] held;
        for (int p = 0; p < N; p++) begin
            bus.s_axis_tvalid[p] = rem[p] > 0 && !pause[p];
            bus.s_axis_tlast[p]  = beat[p] == len[p] - 1;
            bus.s_axis_tdata[p*DW +: DW] = mk(p, beat[p]);
            bus.s_axis_tkeep[p*KW +: KW] = '1;
            bus.s_axis_tuser[p*UW +: UW] = UW'(p + 1);
        end
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            if (bus.s_axis_tvalid[p] && bus.s_axis_tready[p]) begin
                if (beat[p] == len[p] - 1) begin
                    beat[p] = 0;
                    rem[p]  = rem[p] - 1;
                end else begin
                    beat[p] = beat[p] + 1;
                end
            end
        end
        vq.push_back(bus.m_axis_tvalid);
        if (grant != '0) grantq.push_back(grant);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            outq.push_back(bus.m_axis_tdata);
            lastq.push_back(bus.m_axis_tlast);
        end
        stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        held  = bus.m_axis_tdata;
        @(posedge clk);
        #1;
        if (chk_hold && stall) begin
            total++;
            if (!bus.m_axis_tvalid || bus.m_axis_tdata !== held) begin
                bad++;
                $display("FAIL hold_stable got v=%0b d=%0h exp v=1 d=%0h",
                         bus.m_axis_tvalid, bus.m_axis_tdata[15:0], held[15:0]);
            end
        end
        if (toggle) bus.m_axis_tready = ~bus.m_axis_tready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_axis_tvalid = '0;
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        total += 6;
        if (grant !== '0) begin bad++;
            $display("FAIL rst_grant got=%0h exp=0", grant); end
        if (bus.m_axis_tvalid !== 1'b0) begin bad++;
            $display("FAIL rst_mvalid got=%0b exp=0", bus.m_axis_tvalid); end
        if (bus.m_axis_tlast !== 1'b0) begin bad++;
            $display("FAIL rst_mlast got=%0b exp=0", bus.m_axis_tlast); end
        if (bus.m_axis_tdata !== '0 || bus.m_axis_tuser !== '0) begin bad++;
            $display("FAIL rst_mdata got=%0h exp=0", bus.m_axis_tdata[15:0]); end
        if (bus.s_axis_tready !== '0) begin bad++;
            $display("FAIL rst_sready got=%0h exp=0", bus.s_axis_tready); end
        if (cnt !== '0) begin bad++;
            $display("FAIL rst_cnt got=%0h exp=0", cnt[31:0]); end
    endtask

    task automatic test_two_ports();
        int e[6] = '{'h00, 'h01, 'h02, 'h20, 'h21, 'h22};
        int l[6] = '{0, 0, 1, 0, 0, 1};
        int ec[4] = '{1, 0, 1, 0};
        logic [DW-1:0] got;
        do_reset();
        rem[0] = 1; len[0] = 3;
        rem[2] = 1; len[2] = 3;
        repeat (12) cycle();
        total++;
        if (outq.size() != 6) begin bad++;
            $display("FAIL two_ports_count got=%0d exp=6", outq.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < outq.size()) ? outq[i] : '1;
            total++;
            if (got !== DW'(e[i]) || (i < lastq.size() && lastq[i] !== l[i][0])) begin
                bad++;
                $display("FAIL two_ports_beat%0d got=%0h exp=%0h", i, got[15:0], e[i]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            total++;
            if (cnt[p*32 +: 32] !== 32'(ec[p])) begin bad++;
                $display("FAIL two_ports_cnt%0d got=%0d exp=%0d", p, cnt[p*32 +: 32], ec[p]); end
        end
    endtask

    task automatic test_rr_single_beat();
        logic [N-1:0] eg[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [N-1:0] g;
        logic         v;
        do_reset();
        for (int p = 0; p < N; p++) begin rem[p] = 3; len[p] = 1; end
        repeat (12) cycle();
        for (int i = 0; i < 5; i++) begin
            g = (i < grantq.size()) ? grantq[i] : '0;
            total++;
            if (g !== eg[i]) begin bad++;
                $display("FAIL rr_grant%0d got=%0b exp=%0b", i, g, eg[i]); end
        end
        for (int k = 0; k < 8; k++) begin
            v = (k + 2 < vq.size()) ? vq[k+2] : 1'bx;
            total++;
            if (v !== ((k % 2) == 0)) begin bad++;
                $display("FAIL rr_mvalid%0d got=%0b exp=%0b", k, v, (k % 2) == 0); end
        end
    endtask

    task automatic test_backpressure();
        int e[4] = '{'h10, 'h11, 'h12, 'h13};
        logic [DW-1:0] got;
        do_reset();
        rem[1] = 1; len[1] = 4;
        toggle = 1'b1;
        chk_hold = 1'b1;
        repeat (16) cycle();
        chk_hold = 1'b0;
        total++;
        if (outq.size() != 4) begin bad++;
            $display("FAIL bp_count got=%0d exp=4", outq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < outq.size()) ? outq[i] : '1;
            total++;
            if (got !== DW'(e[i])) begin bad++;
                $display("FAIL bp_beat%0d got=%0h exp=%0h", i, got[15:0], e[i]); end
        end
        total++;
        if (lastq.size() < 4 || lastq[3] !== 1'b1) begin bad++;
            $display("FAIL bp_last got=%0d beats exp=tlast on beat 3", lastq.size()); end
    endtask

    task automatic test_drop_valid();
        int e[7] = '{'h30, 'h31, 'h32, 'h33, 'h34, 'h00, 'h01};
        logic [DW-1:0] got;
        int n;
        do_reset();
        rem[3] = 1; len[3] = 5;
        cycle();
        rem[0] = 1; len[0] = 2;
        n = 0;
        while (beat[3] != 2 && n < 20) begin cycle(); n++; end
        total++;
        if (n >= 20) begin bad++;
            $display("FAIL drop_wait got=timeout exp=beat2"); end
        pause[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (grant !== 4'b1000) begin bad++;
                $display("FAIL drop_grant%0d got=%0b exp=1000", i, grant); end
        end
        pause[3] = 1'b0;
        repeat (14) cycle();
        for (int i = 0; i < 7; i++) begin
            got = (i < outq.size()) ? outq[i] : '1;
            total++;
            if (got !== DW'(e[i])) begin bad++;
                $display("FAIL drop_beat%0d got=%0h exp=%0h", i, got[15:0], e[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        do_reset();
        rem[0] = 1; len[0] = 1;
        repeat (4) cycle();
        total++;
        if (cnt[31:0] !== 32'd1) begin bad++;
            $display("FAIL midrst_pre_cnt got=%0d exp=1", cnt[31:0]); end
        rem[2] = 1; len[2] = 4;
        n = 0;
        while (beat[2] != 2 && n < 20) begin cycle(); n++; end
        total++;
        if (n >= 20) begin bad++;
            $display("FAIL midrst_wait got=timeout exp=beat2"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total += 3;
        if (bus.m_axis_tvalid !== 1'b0) begin bad++;
            $display("FAIL midrst_mvalid got=%0b exp=0", bus.m_axis_tvalid); end
        if (grant !== '0) begin bad++;
            $display("FAIL midrst_grant got=%0b exp=0", grant); end
        if (cnt !== '0) begin bad++;
            $display("FAIL midrst_cnt got=%0h exp=0", cnt[31:0]); end
        do_reset();
        rem[1] = 1; len[1] = 2;
        repeat (8) cycle();
        total += 2;
        if (outq.size() != 2 || outq[0] !== DW'('h10) || outq[1] !== DW'('h11)) begin
            bad++;
            $display("FAIL midrst_fresh got=%0d beats exp=2 beats 10,11", outq.size());
        end
        if (cnt[63:32] !== 32'd1) begin bad++;
            $display("FAIL midrst_fresh_cnt got=%0d exp=1", cnt[63:32]); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.g_cnt[0].cnt_q;
        rem[0] = 1; len[0] = 2;
        repeat (8) cycle();
        total += 2;
        if (cnt[31:0] !== 32'd0) begin bad++;
            $display("FAIL wrap_cnt0 got=%0h exp=0", cnt[31:0]); end
        if (outq.size() != 2) begin bad++;
            $display("FAIL wrap_beats got=%0d exp=2", outq.size()); end
    endtask

    initial begin
        test_reset();
        test_two_ports();
        test_rr_single_beat();
        test_backpressure();
        test_drop_valid();
        test_reset_mid_packet();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 256, tdata width; tkeep width SHALL be C_S_AXIS_DATA_WIDTH/8.
REQ-002 Parameter C_S_AXIS_TUSER_WIDTH, default 128, tuser width.
REQ-003 Parameter N_PORTS, default 4, number of AXI-Stream requesters (2..8).
REQ-004 One clock and one reset. Reset is asynchronous and active-high.
REQ-005 axis_aclk  in  1  sole clock; all state on rising edge.
REQ-006 axis_reset  in  1  asynchronous, active-high reset.
REQ-007 s_axis_tdata  in  N_PORTS*DATA  per-port data; port i occupies slice [i*DATA +: DATA].
REQ-008 s_axis_tkeep  in  N_PORTS*DATA/8  per-port byte enables, same slicing.
REQ-009 s_axis_tuser  in  N_PORTS*TUSER  per-port sideband, same slicing.
REQ-010 s_axis_tvalid / s_axis_tlast  in  N_PORTS  per-port valid / end-of-packet.
REQ-011 s_axis_tready  out  N_PORTS  per-port ready.
REQ-012 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DATA/DATA/8/TUSER/1/1  merged output stream.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 o_grant  out  N_PORTS  one-hot current owner; 0 when idle.
REQ-015 o_pkt_cnt  out  N_PORTS*32  per-port forwarded-packet counters.

Function
REQ-016 FSM states IDLE and BUSY.
REQ-017 IDLE: if any s_axis_tvalid=1, latch the winner into o_grant and go to BUSY next cycle; otherwise stay.
REQ-018 Winner: first port with tvalid=1 scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod N_PORTS).
REQ-019 On grant, rr_ptr becomes (winner+1) mod N_PORTS.
REQ-020 BUSY: s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready) for granted port g; all other tready bits 0.
REQ-021 In IDLE all s_axis_tready bits 0.
REQ-022 Packet lock: grant SHALL NOT change until the granted port's tlast beat is accepted.
REQ-023 Accepted tlast beat: return to IDLE next cycle and clear o_grant; one idle cycle between packets is required.
REQ-024 Output register: an accepted input beat appears on m_axis_* exactly one cycle later (latency 1).
REQ-025 m_axis_tvalid clears after an output handshake with no new input beat accepted; m_axis_* data holds while tvalid=1 and tready=0.
REQ-026 Throughput within a packet: 1 beat/cycle while m_axis_tready=1.
REQ-027 o_pkt_cnt[i] increments by 1 on each accepted tlast beat of port i; wraps 0xFFFFFFFF -> 0.
REQ-028 tvalid dropped by the granted port mid-packet: stay in BUSY, no timeout.
REQ-029 tvalid on non-granted ports while BUSY: ignored, no effect on rr_ptr.

Reset
REQ-030 Reset SHALL force: state=IDLE, rr_ptr=0, o_grant=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, all o_pkt_cnt=0.
REQ-031 Reset mid-packet: the in-flight packet is truncated with no tlast emitted; recovery is the requester's responsibility.

Structure
REQ-032 Shared package freq_absorb_pkg SHALL hold the width defaults, N_PORTS default, and FSM state encoding.
REQ-033 The output register SHALL be a sub-module axis_reg_slice (1-deep, forward-registered); the grant FSM and counters stay in the top module.

Verification
REQ-034 Ports 0 and 2 raise tvalid in the same cycle after reset with 3-beat packets; m_axis_tready=1 -> port 0 packet out first, then port 2; o_pkt_cnt = {0,1,0,1}.
REQ-035 All 4 ports continuously valid with 1-beat packets -> grant order 0,1,2,3,0; m_axis_tvalid pattern 1,0 repeating.
REQ-036 Port 1 sends 4 beats while m_axis_tready toggles 1,0,1,0 -> no beat lost or duplicated; each beat is held stable while tready=0.
REQ-037 Port 3 drops tvalid after beat 2 of 5 while port 0 is valid -> grant stays at 3 until its tlast; port 0 is served afterwards.
REQ-038 axis_reset asserted during beat 2 of a 4-beat packet -> the next cycle shows m_axis_tvalid=0, o_grant=0, counters 0; a fresh packet on port 1 is then forwarded normally.
REQ-039 o_pkt_cnt[0] preloaded via force to 0xFFFFFFFF, one port 0 packet -> counter reads 0.
